// File: rtl/vertex_perspective_divide_pkg.sv
// Shared fixed-point definitions for the vertex pipeline: Q16.16 scalars,
// the clip-space vertex type and the common fixed-point multiply.
package vertex_perspective_divide_pkg;

    localparam int FIXEDPOINT_WIDTH = 32;
    localparam int FRAC_BITS        = 16;

    typedef logic signed [FIXEDPOINT_WIDTH-1:0] fixed_t;

    typedef struct packed {
        fixed_t x;
        fixed_t y;
        fixed_t z;
        fixed_t w;
    } Vector4_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_SCALE  = 2'd2,
        ST_OUTPUT = 2'd3
    } vpd_state_e;

    localparam fixed_t FIXED_MAX = {1'b0, {(FIXEDPOINT_WIDTH-1){1'b1}}};

    // Full-precision signed product, rescaled back to FRAC_BITS fraction bits.
    function automatic fixed_t fp_mul(input fixed_t a, input fixed_t b);
        logic signed [2*FIXEDPOINT_WIDTH-1:0] a_w;
        logic signed [2*FIXEDPOINT_WIDTH-1:0] b_w;
        logic signed [2*FIXEDPOINT_WIDTH-1:0] p_w;
        a_w = a;
        b_w = b;
        p_w = a_w * b_w;
        return p_w[FRAC_BITS +: FIXEDPOINT_WIDTH];
    endfunction

endpackage

// File: rtl/vertex_perspective_divide_reciprocal.sv
// Iterative restoring divider producing 1/x in fixed point, one quotient bit
// per cycle; the first bit is resolved on the start edge itself.
module fixed_point_reciprocal
    import vertex_perspective_divide_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_reset_n,
    input  logic   i_start,
    input  fixed_t i_divisor,
    output logic   o_busy,
    output logic   o_done,
    output fixed_t o_recip
);

    localparam int W  = FIXEDPOINT_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(W - 1);

    logic [W-1:0]  divisor_q;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  quot_q;
    logic [CW-1:0] count_q;
    logic          busy_q;
    logic          done_q;
    logic          ovf_q;

    logic [W-1:0]  rem_src_s;
    logic [W-1:0]  div_src_s;
    logic [W-1:0]  quot_src_s;
    logic [W:0]    shifted_s;
    logic [W:0]    rem_next_s;
    logic          take_s;

    // One restoring step; dividend 1 << 2F leaves a partial remainder of 1 above the quotient bits.
    always_comb begin
        rem_src_s  = i_start ? {{(W-1){1'b0}}, 1'b1} : rem_q;
        div_src_s  = i_start ? i_divisor : divisor_q;
        quot_src_s = i_start ? {W{1'b0}} : quot_q;
        shifted_s  = {rem_src_s, 1'b0};
        take_s     = (shifted_s >= {1'b0, div_src_s});
        if (take_s) begin
            rem_next_s = shifted_s - {1'b0, div_src_s};
        end else begin
            rem_next_s = shifted_s;
        end
    end

    // Divider state: load-and-first-step on start, then iterate until the last bit.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            divisor_q <= {W{1'b0}};
            rem_q     <= {W{1'b0}};
            quot_q    <= {W{1'b0}};
            count_q   <= {CW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (i_start) begin
            divisor_q <= i_divisor;
            rem_q     <= rem_next_s[W-1:0];
            quot_q    <= {quot_src_s[W-2:0], take_s};
            count_q   <= {{(CW-1){1'b0}}, 1'b1};
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            ovf_q     <= rem_next_s[W];
        end else if (busy_q) begin
            rem_q   <= rem_next_s[W-1:0];
            quot_q  <= {quot_src_s[W-2:0], take_s};
            count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
            ovf_q   <= ovf_q | rem_next_s[W];
            if (count_q == COUNT_LAST) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_recip = (quot_q[W-1] || ovf_q) ? FIXED_MAX : fixed_t'(quot_q);

endmodule

// File: rtl/vertex_perspective_divide.sv
// Perspective divide and viewport mapping for one clip-space vertex at a time,
// with a valid/ready handshake on both sides.
module vertex_perspective_divide
    import vertex_perspective_divide_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  Vector4_t    i_vector,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_screen_x,
    output logic [15:0] o_screen_y,
    output fixed_t      o_depth,
    output logic        o_clipped
);

    localparam logic signed [63:0] ONE_W  = 64'sd1 <<< FRAC_BITS;
    localparam logic signed [63:0] HALF_W = 64'(SCREEN_WIDTH / 2);
    localparam logic signed [63:0] HALF_H = 64'(SCREEN_HEIGHT / 2);
    localparam logic signed [63:0] X_MAX  = 64'(SCREEN_WIDTH - 1);
    localparam logic signed [63:0] Y_MAX  = 64'(SCREEN_HEIGHT - 1);

    vpd_state_e  state_q, state_d;
    fixed_t      x_q, y_q, z_q;
    logic [15:0] screen_x_q, screen_y_q;
    fixed_t      depth_q;
    logic        clipped_q, valid_q, ready_q;

    logic        capture_s, clip_s, start_s;
    logic        div_busy_s, div_done_s;
    fixed_t      recip_s, ndc_x_s, ndc_y_s, ndc_z_s;
    logic signed [63:0] ndc_x_w, ndc_y_w, px_s, py_s;
    logic [15:0] screen_x_s, screen_y_s;

    fixed_point_reciprocal u_recip (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_start   (start_s),
        .i_divisor (i_vector.w),
        .o_busy    (div_busy_s),
        .o_done    (div_done_s),
        .o_recip   (recip_s)
    );

    // Handshake FSM; a lost divider (not busy, no done) abandons the vertex.
    always_comb begin
        state_d   = state_q;
        capture_s = 1'b0;
        clip_s    = (i_vector.w <= 32'sd0);
        start_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    capture_s = 1'b1;
                    if (clip_s) begin
                        state_d = ST_OUTPUT;
                    end else begin
                        start_s = 1'b1;
                        state_d = ST_DIVIDE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                if (div_done_s) begin
                    state_d = ST_SCALE;
                end else if (div_busy_s) begin
                    state_d = ST_DIVIDE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCALE: state_d = ST_OUTPUT;
            ST_OUTPUT: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUTPUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NDC scaling and viewport mapping; y is flipped so row 0 is the top.
    always_comb begin
        ndc_x_s = fp_mul(x_q, recip_s);
        ndc_y_s = fp_mul(y_q, recip_s);
        ndc_z_s = fp_mul(z_q, recip_s);
        ndc_x_w = ndc_x_s;
        ndc_y_w = ndc_y_s;
        px_s    = ((ndc_x_w + ONE_W) * HALF_W) >>> FRAC_BITS;
        py_s    = ((ONE_W - ndc_y_w) * HALF_H) >>> FRAC_BITS;
        if (px_s < 64'sd0) begin
            screen_x_s = 16'd0;
        end else if (px_s > X_MAX) begin
            screen_x_s = X_MAX[15:0];
        end else begin
            screen_x_s = px_s[15:0];
        end
        if (py_s < 64'sd0) begin
            screen_y_s = 16'd0;
        end else if (py_s > Y_MAX) begin
            screen_y_s = Y_MAX[15:0];
        end else begin
            screen_y_s = py_s[15:0];
        end
    end

    // State, captured vertex and registered result/handshake outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            screen_x_q <= 16'd0;
            screen_y_q <= 16'd0;
            depth_q    <= '0;
            clipped_q  <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == ST_OUTPUT);
            ready_q <= (state_d == ST_IDLE);
            if (capture_s) begin
                x_q <= i_vector.x;
                y_q <= i_vector.y;
                z_q <= i_vector.z;
            end
            if (capture_s && clip_s) begin
                screen_x_q <= 16'd0;
                screen_y_q <= 16'd0;
                depth_q    <= '0;
                clipped_q  <= 1'b1;
            end else if (state_q == ST_SCALE) begin
                screen_x_q <= screen_x_s;
                screen_y_q <= screen_y_s;
                depth_q    <= ndc_z_s;
                clipped_q  <= 1'b0;
            end
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_screen_x = screen_x_q;
    assign o_screen_y = screen_y_q;
    assign o_depth    = depth_q;
    assign o_clipped  = clipped_q;

endmodule

// File: doc/vertex_perspective_divide.md
VERTEX_PERSPECTIVE_DIVIDE -- requirements
Module: vertex_perspective_divide

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 640, viewport width in pixels.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 480, viewport height in pixels.
REQ-003 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  upstream vertex valid.
REQ-006 SHALL have port o_ready  output  1  block can accept a vertex.
REQ-007 SHALL have port i_vector  input  Vector4_t  clip-space vertex from the matrix-multiply stage.
REQ-008 SHALL have port o_valid  output  1  result valid.
REQ-009 SHALL have port i_ready  input  1  downstream accepts result.
REQ-010 SHALL have port o_screen_x  output  16  unsigned pixel column.
REQ-011 SHALL have port o_screen_y  output  16  unsigned pixel row.
REQ-012 SHALL have port o_depth  output  FIXEDPOINT_WIDTH  signed NDC z (z/w).
REQ-013 SHALL have port o_clipped  output  1  vertex rejected (w <= 0).

Function
REQ-014 SHALL implement FSM IDLE -> DIVIDE -> SCALE -> OUTPUT -> IDLE.
REQ-015 o_ready SHALL be 1 only in IDLE; transfer occurs when i_valid && o_ready on a rising edge, capturing i_vector.
REQ-016 On capture with w <= 0 SHALL go directly to OUTPUT with o_clipped=1, o_screen_x=o_screen_y=0, o_depth=0.
REQ-017 DIVIDE SHALL compute recip = 1.0/w in fixed point (dividend 1 << 2F, F = shared fraction-bit count) by restoring division, one quotient bit per cycle, exactly FIXEDPOINT_WIDTH cycles.
REQ-018 Quotient exceeding the max positive value SHALL saturate to the max positive value.
REQ-019 SCALE (1 cycle) SHALL form ndc_x=x*recip, ndc_y=y*recip, ndc_z=z*recip with the shared fixed-point multiply.
REQ-020 o_screen_x SHALL be integer part of (ndc_x+1.0)*SCREEN_WIDTH/2, clamped to [0, SCREEN_WIDTH-1].
REQ-021 o_screen_y SHALL be integer part of (1.0-ndc_y)*SCREEN_HEIGHT/2 (y flipped), clamped to [0, SCREEN_HEIGHT-1].
REQ-022 o_depth SHALL be ndc_z, unclamped.
REQ-023 Latency for w > 0: o_valid SHALL assert FIXEDPOINT_WIDTH+2 cycles after the capture edge; for w <= 0: 1 cycle.
REQ-024 In OUTPUT, o_valid=1 and all outputs SHALL hold stable until i_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-025 No new vertex SHALL be accepted in the same cycle as result handoff (o_ready is 0 in OUTPUT).
REQ-026 i_vector changes outside the capture edge SHALL have no effect.

Reset
REQ-027 While i_reset_n=0, FSM SHALL be IDLE, o_ready=1, o_valid=0, o_clipped=0, o_screen_x=o_screen_y=0, o_depth=0, divider registers 0.
REQ-028 Reset asserted mid-DIVIDE or mid-OUTPUT SHALL abandon the vertex immediately; no result is emitted after deassertion.

Structure
REQ-029 Vector4_t, fixed-point width, fraction-bit count and the fixed-point multiply SHALL come from the shared fixed-point package/header; no local redefinitions.
REQ-030 The iterative divider SHALL be a sub-module fixed_point_reciprocal (start/busy/done, dividend-free 1/x interface).
REQ-031 Viewport mapping and clamping SHALL be in this module.

Verification (FIXEDPOINT_WIDTH=32, F=16, default parameters)
REQ-032 Vertex (0,0,0,1.0) -> after 34 cycles o_valid, screen (320,240), depth 0, clipped 0.
REQ-033 Vertex (2.0,-2.0,1.0,2.0) -> ndc (1,-1,0.5) -> screen (639,479) after clamp, depth 0.5.
REQ-034 Vertex (1,1,1,0) and (1,1,1,-1.0) -> o_valid 1 cycle after capture, clipped 1, outputs 0.
REQ-035 i_ready held 0 for 10 cycles after o_valid -> outputs stable, o_ready 0; i_ready=1 -> IDLE next cycle.
REQ-036 Reset pulsed at cycle 10 of DIVIDE -> all outputs at reset values, o_valid never asserts for that vertex; next vertex processed correctly.
REQ-037 w = 1 LSB -> recip saturates, screen clamps to (639,0) for x,y = 1.0.
